// File: rtl/sand_frame_sequencer.sv
// Per-frame controller for the falling-sand engine: serves brush writes while
// idle, launches the engine on frame ticks, routes the engine's memory ports
// while it runs, then copies scratch RAM into VRAM (clearing RAM) one cell per
// cycle through a two-stage read/write pipeline.
module sand_frame_sequencer #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  frame_tick_i,
  input  logic                  draw_req_i,
  input  logic [ADDR_WIDTH-1:0] draw_addr_i,
  input  logic [DATA_WIDTH-1:0] draw_data_i,
  output logic                  draw_ack_o,
  output logic                  eng_ready_o,
  input  logic                  eng_done_i,
  input  logic [ADDR_WIDTH-1:0] eng_vram_rd_addr_i,
  input  logic [ADDR_WIDTH-1:0] eng_ram_rd_addr_i,
  input  logic [ADDR_WIDTH-1:0] eng_vram_wr_addr_i,
  input  logic [ADDR_WIDTH-1:0] eng_ram_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] eng_vram_wr_data_i,
  input  logic [DATA_WIDTH-1:0] eng_ram_wr_data_i,
  input  logic                  eng_vram_wr_en_i,
  input  logic                  eng_ram_wr_en_i,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic [ADDR_WIDTH-1:0] vram_rd_addr_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_addr_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  vram_wr_en_o,
  output logic                  ram_wr_en_o,
  output logic                  busy_o,
  output logic [15:0]           frame_count_o,
  output logic                  overrun_o
);

  localparam int NCELLS = ACTIVE_COLUMNS * ACTIVE_ROWS;
  // One extra bit so the bound compares cleanly even when NCELLS is a power of two.
  localparam logic [ADDR_WIDTH:0]   N_EXT = (ADDR_WIDTH+1)'(NCELLS);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NCELLS - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, COPY} state_t;

  state_t                state, state_n;
  logic                  tick_pending, tick_pending_n;
  logic [ADDR_WIDTH-1:0] rd_cnt, rd_cnt_n;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n;
  logic                  wr_vld, wr_vld_n;
  logic [15:0]           frame_cnt;
  logic                  overrun;
  logic                  go_start, frame_inc, overrun_set;

  assign frame_count_o = frame_cnt;
  assign overrun_o     = overrun;

  // State, copy pipeline, tick bookkeeping and frame statistics.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      tick_pending <= 1'b0;
      rd_cnt       <= '0;
      wr_addr      <= '0;
      wr_vld       <= 1'b0;
      frame_cnt    <= '0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      tick_pending <= tick_pending_n;
      rd_cnt       <= rd_cnt_n;
      wr_addr      <= wr_addr_n;
      wr_vld       <= wr_vld_n;
      if (frame_inc)   frame_cnt <= frame_cnt + 16'd1;
      if (overrun_set) overrun   <= 1'b1;
    end
  end

  // Next state, memory port muxing and handshakes; everything idles at 0.
  always_comb begin
    state_n        = state;
    rd_cnt_n       = rd_cnt;
    wr_addr_n      = wr_addr;
    wr_vld_n       = wr_vld;
    go_start       = 1'b0;
    frame_inc      = 1'b0;
    draw_ack_o     = 1'b0;
    eng_ready_o    = 1'b0;
    vram_rd_addr_o = '0;
    ram_rd_addr_o  = '0;
    vram_wr_addr_o = '0;
    ram_wr_addr_o  = '0;
    vram_wr_data_o = '0;
    ram_wr_data_o  = '0;
    vram_wr_en_o   = 1'b0;
    ram_wr_en_o    = 1'b0;
    busy_o         = (state != IDLE);

    case (state)
      IDLE: begin
        // The brush write goes out this cycle; a tick seen now still starts
        // the frame next cycle, so the draw never delays the engine.
        if (draw_req_i) begin
          draw_ack_o = 1'b1;
          if ({1'b0, draw_addr_i} < N_EXT) begin
            vram_wr_en_o   = 1'b1;
            vram_wr_addr_o = draw_addr_i;
            vram_wr_data_o = draw_data_i;
          end
        end
        if (tick_pending || frame_tick_i) begin
          go_start = 1'b1;
          state_n  = START;
        end
      end

      START: begin
        eng_ready_o = 1'b1;
        state_n     = RUN;
      end

      RUN: begin
        vram_rd_addr_o = eng_vram_rd_addr_i;
        ram_rd_addr_o  = eng_ram_rd_addr_i;
        vram_wr_addr_o = eng_vram_wr_addr_i;
        ram_wr_addr_o  = eng_ram_wr_addr_i;
        vram_wr_data_o = eng_vram_wr_data_i;
        ram_wr_data_o  = eng_ram_wr_data_i;
        vram_wr_en_o   = eng_vram_wr_en_i;
        ram_wr_en_o    = eng_ram_wr_en_i;
        if (eng_done_i) begin
          // Done cycle doubles as the first copy read (address 0).
          vram_wr_en_o  = 1'b0;
          ram_wr_en_o   = 1'b0;
          ram_rd_addr_o = '0;
          rd_cnt_n      = ADDR_WIDTH'(1);
          wr_addr_n     = '0;
          wr_vld_n      = 1'b1;
          state_n       = COPY;
        end
      end

      COPY: begin
        // Read stage runs one address ahead of the write stage.
        if ({1'b0, rd_cnt} < N_EXT) begin
          ram_rd_addr_o = rd_cnt;
          rd_cnt_n      = rd_cnt + ADDR_WIDTH'(1);
        end
        if (wr_vld) begin
          vram_wr_en_o   = 1'b1;
          vram_wr_addr_o = wr_addr;
          vram_wr_data_o = ram_rd_data_i;
          ram_wr_en_o    = 1'b1;
          ram_wr_addr_o  = wr_addr;
          ram_wr_data_o  = '0;
          wr_addr_n      = wr_addr + ADDR_WIDTH'(1);
          if (wr_addr == LAST) begin
            wr_vld_n  = 1'b0;
            frame_inc = 1'b1;
            state_n   = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    // A tick landing while one is already queued is lost, unless the queued
    // one is being consumed this very cycle.
    if (go_start) tick_pending_n = tick_pending & frame_tick_i;
    else          tick_pending_n = tick_pending | frame_tick_i;
    overrun_set = frame_tick_i & tick_pending & ~go_start;

    // Hold every combinational output quiet while reset is applied.
    if (reset_i) begin
      draw_ack_o     = 1'b0;
      eng_ready_o    = 1'b0;
      vram_rd_addr_o = '0;
      ram_rd_addr_o  = '0;
      vram_wr_addr_o = '0;
      ram_wr_addr_o  = '0;
      vram_wr_data_o = '0;
      ram_wr_data_o  = '0;
      vram_wr_en_o   = 1'b0;
      ram_wr_en_o    = 1'b0;
      busy_o         = 1'b0;
    end
  end

endmodule

// File: tb/tb_sand_frame_sequencer.sv
// Bench for sand_frame_sequencer on a 4x3 grid: memory responders, a
// frame-level model of both cell memories, a draw vector table, scripted
// corner-case sequences and randomized frames.
module tb_sand_frame_sequencer;
  localparam int C = 4, R = 3, N = C * R, AW = 4, DW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, frame_tick_i, draw_req_i, eng_done_i;
  logic [AW-1:0] draw_addr_i;
  logic [DW-1:0] draw_data_i;
  logic          draw_ack_o, eng_ready_o;
  logic [AW-1:0] eng_vram_rd_addr_i, eng_ram_rd_addr_i, eng_vram_wr_addr_i, eng_ram_wr_addr_i;
  logic [DW-1:0] eng_vram_wr_data_i, eng_ram_wr_data_i;
  logic          eng_vram_wr_en_i, eng_ram_wr_en_i;
  logic [DW-1:0] ram_rd_data_i;
  logic [AW-1:0] vram_rd_addr_o, ram_rd_addr_o, vram_wr_addr_o, ram_wr_addr_o;
  logic [DW-1:0] vram_wr_data_o, ram_wr_data_o;
  logic          vram_wr_en_o, ram_wr_en_o, busy_o, overrun_o;
  logic [15:0]   frame_count_o;

  sand_frame_sequencer #(.ACTIVE_COLUMNS(C), .ACTIVE_ROWS(R), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .frame_tick_i(frame_tick_i),
    .draw_req_i(draw_req_i), .draw_addr_i(draw_addr_i), .draw_data_i(draw_data_i),
    .draw_ack_o(draw_ack_o), .eng_ready_o(eng_ready_o), .eng_done_i(eng_done_i),
    .eng_vram_rd_addr_i(eng_vram_rd_addr_i), .eng_ram_rd_addr_i(eng_ram_rd_addr_i),
    .eng_vram_wr_addr_i(eng_vram_wr_addr_i), .eng_ram_wr_addr_i(eng_ram_wr_addr_i),
    .eng_vram_wr_data_i(eng_vram_wr_data_i), .eng_ram_wr_data_i(eng_ram_wr_data_i),
    .eng_vram_wr_en_i(eng_vram_wr_en_i), .eng_ram_wr_en_i(eng_ram_wr_en_i),
    .ram_rd_data_i(ram_rd_data_i),
    .vram_rd_addr_o(vram_rd_addr_o), .ram_rd_addr_o(ram_rd_addr_o),
    .vram_wr_addr_o(vram_wr_addr_o), .ram_wr_addr_o(ram_wr_addr_o),
    .vram_wr_data_o(vram_wr_data_o), .ram_wr_data_o(ram_wr_data_o),
    .vram_wr_en_o(vram_wr_en_o), .ram_wr_en_o(ram_wr_en_o),
    .busy_o(busy_o), .frame_count_o(frame_count_o), .overrun_o(overrun_o)
  );

  // Cell memories driven by the DUT (synchronous write, 1-cycle read).
  logic [DW-1:0] vram [N];
  logic [DW-1:0] ram  [N];
  always @(posedge clk) begin
    if (vram_wr_en_o && vram_wr_addr_o < AW'(N)) vram[vram_wr_addr_o] <= vram_wr_data_o;
    if (ram_wr_en_o && ram_wr_addr_o < AW'(N))   ram[ram_wr_addr_o]   <= ram_wr_data_o;
    ram_rd_data_i <= (ram_rd_addr_o < AW'(N)) ? ram[ram_rd_addr_o] : '0;
  end

  // Reference model: expected memory contents and frame count.
  logic [DW-1:0] mvram [N];
  logic [DW-1:0] mram  [N];
  int mframes;

  int total = 0, bad = 0;

  typedef struct {
    logic req; logic [AW-1:0] addr; logic [DW-1:0] data;
    logic ack; logic wen; logic [AW-1:0] waddr; logic [DW-1:0] wdata;
  } vec_t;
  vec_t tbl [6];

  typedef struct { int cyc; bit to_vram; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t script [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic eng_clear();
    eng_done_i = 0; eng_vram_wr_en_i = 0; eng_ram_wr_en_i = 0;
    eng_vram_rd_addr_i = '0; eng_ram_rd_addr_i = '0;
    eng_vram_wr_addr_i = '0; eng_ram_wr_addr_i = '0;
    eng_vram_wr_data_i = '0; eng_ram_wr_data_i = '0;
  endtask

  task automatic mem_cmp(input string nm);
    int e = 0;
    for (int a = 0; a < N; a++) begin
      if (vram[a] !== mvram[a]) e++;
      if (ram[a] !== mram[a]) e++;
    end
    chk(nm, 32'(e), 0);
  endtask

  // One IDLE brush write; expectation from the address range rule.
  task automatic draw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit inr = (int'(a) < N);
    @(posedge clk); #1;
    draw_req_i = 1; draw_addr_i = a; draw_data_i = d;
    @(negedge clk);
    chk("draw_ack", 32'(draw_ack_o), 1);
    chk("draw_wen", 32'(vram_wr_en_o), 32'(inr));
    if (inr) begin
      chk("draw_waddr", 32'(vram_wr_addr_o), 32'(a));
      chk("draw_wdata", 32'(vram_wr_data_o), 32'(d));
      mvram[a] = d;
    end
    @(posedge clk); #1;
    draw_req_i = 0;
  endtask

  // Tick in IDLE; ends at negedge of the START cycle.
  task automatic start_frame();
    @(posedge clk); #1;
    frame_tick_i = 1;
    @(negedge clk);
    chk("tick_ready_early", 32'(eng_ready_o), 0);
    @(posedge clk); #1;
    frame_tick_i = 0;
    @(negedge clk);
    chk("start_ready", 32'(eng_ready_o), 1);
    chk("start_busy", 32'(busy_o), 1);
  endtask

  // RUN phase of `len` cycles; done on the last one. Ends at posedge+1 of COPY cycle 1.
  task automatic engine(input int len, input bit rnd, input int t1, input int t2);
    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      eng_clear();
      frame_tick_i = (c == t1 || c == t2);
      eng_vram_rd_addr_i = AW'($urandom_range(0, N-1));
      eng_ram_rd_addr_i  = AW'($urandom_range(0, N-1));
      if (rnd) begin
        eng_vram_wr_en_i   = 1'($urandom_range(0, 1));
        eng_vram_wr_addr_i = AW'($urandom_range(0, N-1));
        eng_vram_wr_data_i = DW'($urandom_range(0, 3));
        eng_ram_wr_en_i    = 1'($urandom_range(0, 1));
        eng_ram_wr_addr_i  = AW'($urandom_range(0, N-1));
        eng_ram_wr_data_i  = DW'($urandom_range(0, 3));
      end else begin
        foreach (script[i]) if (script[i].cyc == c) begin
          if (script[i].to_vram) begin
            eng_vram_wr_en_i = 1; eng_vram_wr_addr_i = script[i].addr; eng_vram_wr_data_i = script[i].data;
          end else begin
            eng_ram_wr_en_i = 1; eng_ram_wr_addr_i = script[i].addr; eng_ram_wr_data_i = script[i].data;
          end
        end
      end
      eng_done_i = (c == len);
      if (c != len) begin
        if (eng_vram_wr_en_i) mvram[eng_vram_wr_addr_i] = eng_vram_wr_data_i;
        if (eng_ram_wr_en_i)  mram[eng_ram_wr_addr_i]   = eng_ram_wr_data_i;
      end
      @(negedge clk);
      chk("run_busy", 32'(busy_o), 1);
      if (draw_req_i) chk("run_no_ack", 32'(draw_ack_o), 0);
      if (c == len) begin
        chk("done_vwen", 32'(vram_wr_en_o), 0);
        chk("done_rwen", 32'(ram_wr_en_o), 0);
        chk("done_rdaddr", 32'(ram_rd_addr_o), 0);
      end else begin
        chk("run_vwen", 32'(vram_wr_en_o), 32'(eng_vram_wr_en_i));
        chk("run_rwen", 32'(ram_wr_en_o), 32'(eng_ram_wr_en_i));
        chk("run_vrd", 32'(vram_rd_addr_o), 32'(eng_vram_rd_addr_i));
        chk("run_rrd", 32'(ram_rd_addr_o), 32'(eng_ram_rd_addr_i));
        if (eng_ram_wr_en_i) chk("run_rwaddr", 32'(ram_wr_addr_o), 32'(eng_ram_wr_addr_i));
      end
    end
    @(posedge clk); #1;
    eng_clear();
    frame_tick_i = 0;
  endtask

  // COPY cycle k+1 must write cell k; checks the first `lim` cycles.
  task automatic copy_check(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      chk("copy_vwen", 32'(vram_wr_en_o), 1);
      chk("copy_vaddr", 32'(vram_wr_addr_o), 32'(k));
      chk("copy_vdata", 32'(vram_wr_data_o), 32'(mram[k]));
      chk("copy_rwen", 32'(ram_wr_en_o), 1);
      chk("copy_raddr", 32'(ram_wr_addr_o), 32'(k));
      chk("copy_rdata", 32'(ram_wr_data_o), 0);
      if (k < N-1) chk("copy_rdaddr", 32'(ram_rd_addr_o), 32'(k+1));
      if (draw_req_i) chk("copy_no_ack", 32'(draw_ack_o), 0);
      @(posedge clk); #1;
    end
  endtask

  // Frame end: scratch becomes the frame, scratch is emptied. Ends at negedge of first IDLE cycle.
  task automatic close_frame();
    for (int a = 0; a < N; a++) begin mvram[a] = mram[a]; mram[a] = '0; end
    mframes++;
    @(negedge clk);
    chk("frame_count", 32'(frame_count_o), 32'(mframes));
    chk("idle_busy", 32'(busy_o), 0);
    mem_cmp("mem_after_copy");
  endtask

  initial begin
    reset_i = 1; frame_tick_i = 0; draw_req_i = 0; draw_addr_i = '0; draw_data_i = '0;
    eng_clear();
    mframes = 0;
    for (int a = 0; a < N; a++) begin
      vram[a] = DW'($urandom_range(0, 3)); ram[a] = DW'($urandom_range(0, 3));
      mvram[a] = vram[a]; mram[a] = ram[a];
    end
    tbl[0] = '{1'b1, 4'd0,  2'd1, 1'b1, 1'b1, 4'd0,  2'd1};
    tbl[1] = '{1'b1, 4'd11, 2'd2, 1'b1, 1'b1, 4'd11, 2'd2};
    tbl[2] = '{1'b1, 4'd12, 2'd1, 1'b1, 1'b0, 4'd0,  2'd0};
    tbl[3] = '{1'b1, 4'd15, 2'd3, 1'b1, 1'b0, 4'd0,  2'd0};
    tbl[4] = '{1'b0, 4'd5,  2'd2, 1'b0, 1'b0, 4'd0,  2'd0};
    tbl[5] = '{1'b1, 4'd7,  2'd0, 1'b1, 1'b1, 4'd7,  2'd0};

    // 1. reset and first tick
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_reset_wen", 32'({vram_wr_en_o, ram_wr_en_o, busy_o}), 0);
    @(posedge clk); #1;
    reset_i = 0;
    @(negedge clk);
    chk("rst_addrs", 32'({vram_rd_addr_o, ram_rd_addr_o, vram_wr_addr_o, ram_wr_addr_o}), 0);
    chk("rst_ctl", 32'({draw_ack_o, eng_ready_o, vram_wr_data_o, ram_wr_data_o, vram_wr_en_o, ram_wr_en_o, busy_o, overrun_o}), 0);
    chk("rst_frames", 32'(frame_count_o), 0);

    // Draw vector table in IDLE
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      draw_req_i = tbl[i].req; draw_addr_i = tbl[i].addr; draw_data_i = tbl[i].data;
      @(negedge clk);
      chk("tbl_ack", 32'(draw_ack_o), 32'(tbl[i].ack));
      chk("tbl_wen", 32'(vram_wr_en_o), 32'(tbl[i].wen));
      chk("tbl_waddr", 32'(vram_wr_addr_o), 32'(tbl[i].waddr));
      chk("tbl_wdata", 32'(vram_wr_data_o), 32'(tbl[i].wdata));
      chk("tbl_busy", 32'(busy_o), 0);
      if (tbl[i].req && int'(tbl[i].addr) < N) mvram[tbl[i].addr] = tbl[i].data;
    end
    @(posedge clk); #1;
    draw_req_i = 0;

    // 2. scripted engine frame
    start_frame();
    script.push_back('{1, 1'b0, 4'd5, 2'd1});
    script.push_back('{2, 1'b1, 4'd1, 2'd0});
    script.push_back('{20, 1'b0, 4'd7, 2'd2});  // presented on the done cycle: must be dropped
    engine(20, 0, 0, 0);
    copy_check(N);
    close_frame();
    chk("s2_vram5", 32'(vram[5]), 1);
    begin
      int nz = 0;
      for (int a = 0; a < N; a++) if (ram[a] != '0) nz++;
      chk("s2_ram_clear", 32'(nz), 0);
    end
    chk("s2_frames", 32'(frame_count_o), 1);

    // 3. draw held through a frame, acked only once back in IDLE
    start_frame();
    draw_req_i = 1; draw_addr_i = 4'd3; draw_data_i = 2'd2;
    engine(6, 1, 0, 0);
    copy_check(N);
    close_frame();
    chk("s3_ack", 32'(draw_ack_o), 1);
    chk("s3_wen", 32'(vram_wr_en_o), 1);
    chk("s3_waddr", 32'(vram_wr_addr_o), 3);
    chk("s3_wdata", 32'(vram_wr_data_o), 2);
    mvram[3] = 2'd2;
    @(posedge clk); #1;
    draw_req_i = 0;
    draw(4'd12, 2'd1);

    // 4. draw and tick in the same IDLE cycle
    @(posedge clk); #1;
    draw_req_i = 1; draw_addr_i = 4'd2; draw_data_i = 2'd1; frame_tick_i = 1;
    @(negedge clk);
    chk("s4_ack", 32'(draw_ack_o), 1);
    chk("s4_wen", 32'(vram_wr_en_o), 1);
    chk("s4_waddr", 32'(vram_wr_addr_o), 2);
    chk("s4_ready_early", 32'(eng_ready_o), 0);
    mvram[2] = 2'd1;
    @(posedge clk); #1;
    draw_req_i = 0; frame_tick_i = 0;
    @(negedge clk);
    chk("s4_ready", 32'(eng_ready_o), 1);
    engine(4, 1, 0, 0);
    copy_check(N);
    close_frame();

    // 5. two ticks in one RUN: overrun, then back-to-back frame
    start_frame();
    engine(8, 1, 2, 5);
    copy_check(N);
    close_frame();
    chk("s5_overrun", 32'(overrun_o), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s5_restart", 32'(eng_ready_o), 1);
    engine(3, 1, 0, 0);
    copy_check(N);
    close_frame();
    chk("s5_overrun_sticky", 32'(overrun_o), 1);

    // 6. reset while COPY writes cell 6
    start_frame();
    engine(5, 1, 0, 0);
    copy_check(6);
    reset_i = 1;
    @(negedge clk);
    chk("s6_rst_vwen", 32'(vram_wr_en_o), 0);
    chk("s6_rst_rwen", 32'(ram_wr_en_o), 0);
    @(posedge clk); #1;
    reset_i = 0;
    for (int a = 0; a < 6; a++) begin mvram[a] = mram[a]; mram[a] = '0; end
    mframes = 0;
    @(negedge clk);
    chk("s6_wen", 32'({vram_wr_en_o, ram_wr_en_o}), 0);
    chk("s6_busy", 32'(busy_o), 0);
    chk("s6_frames", 32'(frame_count_o), 0);
    chk("s6_overrun", 32'(overrun_o), 0);
    mem_cmp("s6_mem");
    @(posedge clk); #1;
    eng_done_i = 1; eng_ram_wr_en_i = 1; eng_ram_wr_addr_i = 4'd4;
    @(negedge clk);
    chk("s6_idle_eng_wen", 32'(ram_wr_en_o), 0);
    @(posedge clk); #1;
    eng_clear();
    @(negedge clk);
    chk("s6_done_ignored", 32'(busy_o), 0);
    start_frame();
    engine(7, 1, 0, 0);
    copy_check(N);
    close_frame();

    // Randomized frames with random brush traffic
    for (int f = 0; f < 8; f++) begin
      int nd = $urandom_range(0, 3);
      for (int d = 0; d < nd; d++) draw(AW'($urandom_range(0, 15)), DW'($urandom_range(0, 3)));
      start_frame();
      engine($urandom_range(1, 15), 1, 0, 0);
      copy_check(N);
      close_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
